jelly_vdma_write_regs: RTL and testbench
========================================

// Module: jelly_vdma_write_regs
// PURPOSE
//  WISHBONE slave register block for the video write DMA (byte base 0x40021000); the responder for the peri-bus master.
//  Holds the programmed frame parameters and control/status. Commits a shadow copy to the DMA core at frame start.
//  Lives entirely in the wb_clk_i domain; the core-side strobes arrive already synchronised.
// PARAMETERS
//  WB_ADR_WIDTH   8            word-address width (byte address >> 2); only the low 5 bits are decoded
//  WB_DAT_WIDTH   32           data width; WB_SEL_WIDTH = WB_DAT_WIDTH/8
//  ADDR_WIDTH     32           DMA base-address register width
//  INDEX_WIDTH    8            update-commit counter width
//  CORE_ID        32'h527a0110 read-only ID value
//  CORE_VERSION   32'h00010000 read-only version value
//  INIT_CTL       3'b000       reset value of CONTROL[2:0]
//  INIT_ADDR/STRIDE/WIDTH/HEIGHT/SIZE/AWLEN  0,0,0,0,0,8'd15  register reset values
// PORTS
//  wb_rst_i       in   1       reset, asynchronous, active-low
//  wb_clk_i       in   1       clock
//  s_wb_adr_i     in   WB_ADR_WIDTH  word address
//  s_wb_dat_i     in   WB_DAT_WIDTH  write data
//  s_wb_dat_o     out  WB_DAT_WIDTH  read data
//  s_wb_we_i      in   1       write enable
//  s_wb_sel_i     in   WB_SEL_WIDTH  byte lanes
//  s_wb_stb_i     in   1       strobe
//  s_wb_ack_o     out  1       acknowledge
//  core_frame_start in 1       1-cycle pulse, core about to begin a frame
//  core_frame_done  in 1       1-cycle pulse, core finished a frame
//  core_busy      in   1       core transfer in progress
//  core_enable    out  1       run enable to core
//  core_addr/stride/width/height/size/awlen  out  ADDR_WIDTH/32/32/32/32/8  committed shadow params
//  irq            out  1       level interrupt (tied 0 without JELLY_VDMA_WRITE_REGS_IRQ_EN)
// BEHAVIOUR
//  Map (word idx): 00 CORE_ID(ro) 01 VERSION(ro) 04 CONTROL 05 STATUS(ro) 06 INDEX(ro) 08 ADDR 09 STRIDE
//   0A WIDTH 0B HEIGHT 0C SIZE 0F AWLEN 10 IRQ_ENABLE 11 IRQ_STATUS(W1C). Unmapped: reads 0, writes ignored, still acked.
//  Handshake: ack registered. Accept when stb=1 and ack=0; ack=1 for exactly one cycle, the cycle after acceptance.
//   A stb held high therefore gets ack every other cycle, one access per ack.
//   Writes take effect on the acceptance edge, per byte lane (sel). Bits above the register width are dropped.
//   dat_o is registered and valid while ack=1; reads are zero-extended. dat_o is 0 when ack=0.
//  CONTROL[0] enable -> core_enable. CONTROL[1] update request. CONTROL[2] oneshot.
//  STATUS[0] = core_busy; STATUS[1] = CONTROL[1] (update pending); STATUS[2] = core_enable.
//  Commit: on core_frame_start with CONTROL[1]=1, all shadow outputs load from the registers on that edge.
//   On the same edge CONTROL[1] clears and INDEX increments, wrapping at 2^INDEX_WIDTH.
//   core_frame_start with CONTROL[1]=0 leaves the shadows unchanged.
//  Oneshot: core_frame_done with CONTROL[2]=1 clears CONTROL[0] on that edge.
//  Simultaneous events: a bus write to CONTROL in the same cycle as an auto-clear wins (written value kept).
//   A bus write to a param in the commit cycle: the shadow takes the old value, the register takes the new one.
//  Reset (wb_rst_i=0, async): ack=0, dat_o=0, CONTROL=INIT_CTL, INDEX=0, regs=INIT_*, shadows=INIT_*, irq=0.
//   Mid-access reset drops the access; no ack is issued afterwards for it.
// CONFIGURATION
//  `JELLY_VDMA_WRITE_REGS_IRQ_EN defined:
//   IRQ_STATUS[0] sets on core_frame_done; IRQ_STATUS[1] sets on commit. A W1C write clears the bits.
//   A set event wins over a clear in the same cycle. irq = |(IRQ_STATUS & IRQ_ENABLE[1:0]), registered.
//  Undefined: IRQ_ENABLE/IRQ_STATUS read 0 and ignore writes; irq is constant 0; no IRQ flops are instantiated.
// STRUCTURE
//  Package jelly_vdma_write_regs_pkg: word-index localparams (REGADR_*), CONTROL/STATUS bit positions,
//   and a params struct typedef {addr,stride,width,height,size,awlen} used for both the register and shadow copies.
//  Sub-module jelly_wb_reg_ack: accept/ack pulse generator plus registered read mux enable. Reusable by other peri slaves.
// TESTING
//  1 Read word 00 after reset -> dat_o=CORE_ID, ack high exactly 1 cycle; word 0F reads 15.
//  2 Write WIDTH=2048 with sel=4'b0011, then sel=4'b1111 value 0x12345678 -> reads back 0x0800, then 0x12345678.
//  3 Write params, CONTROL=3, pulse core_frame_start -> core_width etc. update that edge, STATUS[1]=0, INDEX=1.
//  4 CONTROL=7, pulse core_frame_done -> core_enable=0, CONTROL reads 6;
//    a CONTROL=7 write in the same cycle instead -> reads 7.
//  5 Hold stb=1 for 6 cycles (reads) -> exactly 3 ack pulses; reset mid-access -> ack stays 0.
//  6 IRQ_EN build: IRQ_ENABLE=1, frame_done -> irq=1 next cycle; W1C IRQ_STATUS=1 -> irq=0.

Source files
------------

// File: rtl/jelly_vdma_write_regs_pkg.sv
// Shared definitions for the video write DMA register block: register map,
// CONTROL/STATUS bit positions and the frame parameter record.
package jelly_vdma_write_regs_pkg;

  localparam logic [4:0] REGADR_CORE_ID      = 5'h00;
  localparam logic [4:0] REGADR_CORE_VERSION = 5'h01;
  localparam logic [4:0] REGADR_CONTROL      = 5'h04;
  localparam logic [4:0] REGADR_STATUS       = 5'h05;
  localparam logic [4:0] REGADR_INDEX        = 5'h06;
  localparam logic [4:0] REGADR_ADDR         = 5'h08;
  localparam logic [4:0] REGADR_STRIDE       = 5'h09;
  localparam logic [4:0] REGADR_WIDTH        = 5'h0a;
  localparam logic [4:0] REGADR_HEIGHT       = 5'h0b;
  localparam logic [4:0] REGADR_SIZE         = 5'h0c;
  localparam logic [4:0] REGADR_AWLEN        = 5'h0f;
  localparam logic [4:0] REGADR_IRQ_ENABLE   = 5'h10;
  localparam logic [4:0] REGADR_IRQ_STATUS   = 5'h11;

  localparam int unsigned CTL_ENABLE  = 0;
  localparam int unsigned CTL_UPDATE  = 1;
  localparam int unsigned CTL_ONESHOT = 2;

  localparam int unsigned STS_BUSY    = 0;
  localparam int unsigned STS_PENDING = 1;
  localparam int unsigned STS_ENABLE  = 2;

  // Storage width of the address field; the top truncates to its ADDR_WIDTH.
  localparam int unsigned PARAM_ADDR_WIDTH = 32;

  typedef struct packed {
    logic [PARAM_ADDR_WIDTH-1:0] addr;
    logic [31:0]                 stride;
    logic [31:0]                 width;
    logic [31:0]                 height;
    logic [31:0]                 size;
    logic [7:0]                  awlen;
  } vdma_params_t;

endpackage

// File: rtl/jelly_wb_reg_ack.sv
// WISHBONE slave handshake: one-cycle registered ack per accepted strobe and
// a registered read-data latch that is zero whenever ack is low.
module jelly_wb_reg_ack #(
  parameter int unsigned DAT_WIDTH = 32
) (
  input  logic                 wb_rst_i,
  input  logic                 wb_clk_i,
  input  logic                 s_wb_stb_i,
  input  logic [DAT_WIDTH-1:0] rd_data,
  output logic                 s_wb_ack_o,
  output logic [DAT_WIDTH-1:0] s_wb_dat_o,
  output logic                 accept
);

  assign accept = s_wb_stb_i & ~s_wb_ack_o;

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      s_wb_ack_o <= 1'b0;
      s_wb_dat_o <= '0;
    end else begin
      s_wb_ack_o <= accept;
      s_wb_dat_o <= accept ? rd_data : '0;
    end
  end

endmodule

// File: rtl/jelly_vdma_write_regs.sv
// Video write DMA register block with frame-start shadow commit.
// Optional interrupt logic: define JELLY_VDMA_WRITE_REGS_IRQ_EN.
module jelly_vdma_write_regs
  import jelly_vdma_write_regs_pkg::*;
#(
  parameter int unsigned           WB_ADR_WIDTH = 8,
  parameter int unsigned           WB_DAT_WIDTH = 32,
  parameter int unsigned           WB_SEL_WIDTH = WB_DAT_WIDTH / 8,
  parameter int unsigned           ADDR_WIDTH   = 32,
  parameter int unsigned           INDEX_WIDTH  = 8,
  parameter logic [31:0]           CORE_ID      = 32'h527a0110,
  parameter logic [31:0]           CORE_VERSION = 32'h00010000,
  parameter logic [2:0]            INIT_CTL     = 3'b000,
  parameter logic [ADDR_WIDTH-1:0] INIT_ADDR    = '0,
  parameter logic [31:0]           INIT_STRIDE  = '0,
  parameter logic [31:0]           INIT_WIDTH   = '0,
  parameter logic [31:0]           INIT_HEIGHT  = '0,
  parameter logic [31:0]           INIT_SIZE    = '0,
  parameter logic [7:0]            INIT_AWLEN   = 8'd15
) (
  input  logic                    wb_rst_i,
  input  logic                    wb_clk_i,
  input  logic [WB_ADR_WIDTH-1:0] s_wb_adr_i,
  input  logic [WB_DAT_WIDTH-1:0] s_wb_dat_i,
  output logic [WB_DAT_WIDTH-1:0] s_wb_dat_o,
  input  logic                    s_wb_we_i,
  input  logic [WB_SEL_WIDTH-1:0] s_wb_sel_i,
  input  logic                    s_wb_stb_i,
  output logic                    s_wb_ack_o,
  input  logic                    core_frame_start,
  input  logic                    core_frame_done,
  input  logic                    core_busy,
  output logic                    core_enable,
  output logic [ADDR_WIDTH-1:0]   core_addr,
  output logic [31:0]             core_stride,
  output logic [31:0]             core_width,
  output logic [31:0]             core_height,
  output logic [31:0]             core_size,
  output logic [7:0]              core_awlen,
  output logic                    irq
);

  function automatic logic [WB_DAT_WIDTH-1:0] wb_merge(
    input logic [WB_DAT_WIDTH-1:0] cur,
    input logic [WB_DAT_WIDTH-1:0] wdat,
    input logic [WB_SEL_WIDTH-1:0] sel
  );
    logic [WB_DAT_WIDTH-1:0] r;
    r = cur;
    for (int unsigned i = 0; i < WB_SEL_WIDTH; i++) begin
      if (sel[i]) r[i*8 +: 8] = wdat[i*8 +: 8];
    end
    return r;
  endfunction

  localparam vdma_params_t INIT_PARAMS = '{
    addr:   PARAM_ADDR_WIDTH'(INIT_ADDR),
    stride: INIT_STRIDE,
    width:  INIT_WIDTH,
    height: INIT_HEIGHT,
    size:   INIT_SIZE,
    awlen:  INIT_AWLEN
  };

  logic [4:0]              reg_adr;
  logic                    unused_adr;
  logic                    accept;
  logic                    wr_en;
  logic                    commit;
  logic [WB_DAT_WIDTH-1:0] rd_data;
  logic [2:0]              ctl;
  logic [2:0]              ctl_next;
  logic [INDEX_WIDTH-1:0]  index;
  vdma_params_t            regs;
  vdma_params_t            shadow;
  logic [WB_DAT_WIDTH-1:0] irq_en_rd;
  logic [WB_DAT_WIDTH-1:0] irq_st_rd;

  assign reg_adr    = s_wb_adr_i[4:0];
  assign unused_adr = ^s_wb_adr_i[WB_ADR_WIDTH-1:5];
  assign wr_en      = accept & s_wb_we_i;
  assign commit     = core_frame_start & ctl[CTL_UPDATE];

  jelly_wb_reg_ack #(
    .DAT_WIDTH (WB_DAT_WIDTH)
  ) u_ack (
    .wb_rst_i   (wb_rst_i),
    .wb_clk_i   (wb_clk_i),
    .s_wb_stb_i (s_wb_stb_i),
    .rd_data    (rd_data),
    .s_wb_ack_o (s_wb_ack_o),
    .s_wb_dat_o (s_wb_dat_o),
    .accept     (accept)
  );

  // Auto-clears apply first so a coincident bus write to CONTROL overrides them.
  always_comb begin
    ctl_next = ctl;
    if (commit) ctl_next[CTL_UPDATE] = 1'b0;
    if (core_frame_done && ctl[CTL_ONESHOT]) ctl_next[CTL_ENABLE] = 1'b0;
    if (wr_en && reg_adr == REGADR_CONTROL && s_wb_sel_i[0]) ctl_next = s_wb_dat_i[2:0];
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      ctl    <= INIT_CTL;
      index  <= '0;
      regs   <= INIT_PARAMS;
      shadow <= INIT_PARAMS;
    end else begin
      ctl <= ctl_next;
      if (commit) begin
        shadow <= regs;
        index  <= index + 1'b1;
      end
      if (wr_en) begin
        case (reg_adr)
          REGADR_ADDR:   regs.addr   <= PARAM_ADDR_WIDTH'(ADDR_WIDTH'(wb_merge(WB_DAT_WIDTH'(regs.addr), s_wb_dat_i, s_wb_sel_i)));
          REGADR_STRIDE: regs.stride <= 32'(wb_merge(WB_DAT_WIDTH'(regs.stride), s_wb_dat_i, s_wb_sel_i));
          REGADR_WIDTH:  regs.width  <= 32'(wb_merge(WB_DAT_WIDTH'(regs.width), s_wb_dat_i, s_wb_sel_i));
          REGADR_HEIGHT: regs.height <= 32'(wb_merge(WB_DAT_WIDTH'(regs.height), s_wb_dat_i, s_wb_sel_i));
          REGADR_SIZE:   regs.size   <= 32'(wb_merge(WB_DAT_WIDTH'(regs.size), s_wb_dat_i, s_wb_sel_i));
          REGADR_AWLEN:  regs.awlen  <= 8'(wb_merge(WB_DAT_WIDTH'(regs.awlen), s_wb_dat_i, s_wb_sel_i));
          default: ;
        endcase
      end
    end
  end

`ifdef JELLY_VDMA_WRITE_REGS_IRQ_EN
  logic [1:0] irq_enable;
  logic [1:0] irq_enable_next;
  logic [1:0] irq_status;
  logic [1:0] irq_status_next;

  // Set events are OR-ed in after the W1C clear, so they win a same-cycle tie.
  always_comb begin
    irq_enable_next = irq_enable;
    irq_status_next = irq_status;
    if (wr_en && reg_adr == REGADR_IRQ_ENABLE && s_wb_sel_i[0]) irq_enable_next = s_wb_dat_i[1:0];
    if (wr_en && reg_adr == REGADR_IRQ_STATUS && s_wb_sel_i[0]) irq_status_next = irq_status & ~s_wb_dat_i[1:0];
    irq_status_next = irq_status_next | {commit, core_frame_done};
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      irq_enable <= '0;
      irq_status <= '0;
      irq        <= 1'b0;
    end else begin
      irq_enable <= irq_enable_next;
      irq_status <= irq_status_next;
      irq        <= |(irq_status_next & irq_enable_next);
    end
  end

  assign irq_en_rd = WB_DAT_WIDTH'(irq_enable);
  assign irq_st_rd = WB_DAT_WIDTH'(irq_status);
`else
  assign irq       = 1'b0;
  assign irq_en_rd = '0;
  assign irq_st_rd = '0;
`endif

  always_comb begin
    rd_data = '0;
    case (reg_adr)
      REGADR_CORE_ID:      rd_data = WB_DAT_WIDTH'(CORE_ID);
      REGADR_CORE_VERSION: rd_data = WB_DAT_WIDTH'(CORE_VERSION);
      REGADR_CONTROL:      rd_data = WB_DAT_WIDTH'(ctl);
      REGADR_STATUS:       rd_data = WB_DAT_WIDTH'({ctl[CTL_ENABLE], ctl[CTL_UPDATE], core_busy});
      REGADR_INDEX:        rd_data = WB_DAT_WIDTH'(index);
      REGADR_ADDR:         rd_data = WB_DAT_WIDTH'(regs.addr);
      REGADR_STRIDE:       rd_data = WB_DAT_WIDTH'(regs.stride);
      REGADR_WIDTH:        rd_data = WB_DAT_WIDTH'(regs.width);
      REGADR_HEIGHT:       rd_data = WB_DAT_WIDTH'(regs.height);
      REGADR_SIZE:         rd_data = WB_DAT_WIDTH'(regs.size);
      REGADR_AWLEN:        rd_data = WB_DAT_WIDTH'(regs.awlen);
      REGADR_IRQ_ENABLE:   rd_data = irq_en_rd;
      REGADR_IRQ_STATUS:   rd_data = irq_st_rd;
      default:             rd_data = '0;
    endcase
  end

  assign core_enable = ctl[CTL_ENABLE];
  assign core_addr   = ADDR_WIDTH'(shadow.addr);
  assign core_stride = shadow.stride;
  assign core_width  = shadow.width;
  assign core_height = shadow.height;
  assign core_size   = shadow.size;
  assign core_awlen  = shadow.awlen;

endmodule

// File: tb/tb_jelly_vdma_write_regs.sv
// Directed bench for jelly_vdma_write_regs: bus handshake, byte lanes,
// shadow commit, oneshot, reset, and interrupts when JELLY_VDMA_WRITE_REGS_IRQ_EN is set.
module tb_jelly_vdma_write_regs;

  logic        wb_rst_i = 1'b0;
  logic        wb_clk_i = 1'b0;
  logic [7:0]  s_wb_adr_i = '0;
  logic [31:0] s_wb_dat_i = '0;
  logic [31:0] s_wb_dat_o;
  logic        s_wb_we_i = 1'b0;
  logic [3:0]  s_wb_sel_i = '0;
  logic        s_wb_stb_i = 1'b0;
  logic        s_wb_ack_o;
  logic        core_frame_start = 1'b0;
  logic        core_frame_done = 1'b0;
  logic        core_busy = 1'b0;
  logic        core_enable;
  logic [31:0] core_addr, core_stride, core_width, core_height, core_size;
  logic [7:0]  core_awlen;
  logic        irq;

  int checks = 0;
  int errors = 0;

  jelly_vdma_write_regs dut (
    .wb_rst_i         (wb_rst_i),
    .wb_clk_i         (wb_clk_i),
    .s_wb_adr_i       (s_wb_adr_i),
    .s_wb_dat_i       (s_wb_dat_i),
    .s_wb_dat_o       (s_wb_dat_o),
    .s_wb_we_i        (s_wb_we_i),
    .s_wb_sel_i       (s_wb_sel_i),
    .s_wb_stb_i       (s_wb_stb_i),
    .s_wb_ack_o       (s_wb_ack_o),
    .core_frame_start (core_frame_start),
    .core_frame_done  (core_frame_done),
    .core_busy        (core_busy),
    .core_enable      (core_enable),
    .core_addr        (core_addr),
    .core_stride      (core_stride),
    .core_width       (core_width),
    .core_height      (core_height),
    .core_size        (core_size),
    .core_awlen       (core_awlen),
    .irq              (irq)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One bus access, optionally with core pulses coincident with the acceptance edge.
  task automatic wb_xfer(input logic [7:0] adr, input logic we, input logic [31:0] dat,
                         input logic [3:0] sel, input logic fs, input logic fd,
                         output logic [31:0] rdat);
    logic got;
    got  = 1'b0;
    rdat = '0;
    @(negedge wb_clk_i);
    s_wb_adr_i = adr; s_wb_we_i = we; s_wb_dat_i = dat; s_wb_sel_i = sel; s_wb_stb_i = 1'b1;
    core_frame_start = fs; core_frame_done = fd;
    for (int i = 0; i < 4; i++) begin
      @(posedge wb_clk_i); #1;
      core_frame_start = 1'b0; core_frame_done = 1'b0;
      if (s_wb_ack_o) begin
        got  = 1'b1;
        rdat = s_wb_dat_o;
        break;
      end
    end
    s_wb_stb_i = 1'b0; s_wb_we_i = 1'b0;
    checks++;
    if (got !== 1'b1) begin
      errors++;
      $display("FAIL ack_timeout adr=%h got=%b need=1", adr, got);
    end
  endtask

  task automatic wb_write(input logic [7:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] d;
    wb_xfer(adr, 1'b1, dat, sel, 1'b0, 1'b0, d);
  endtask

  task automatic wb_read(input logic [7:0] adr, output logic [31:0] d);
    wb_xfer(adr, 1'b0, '0, 4'hf, 1'b0, 1'b0, d);
  endtask

  task automatic pulse_start();
    @(negedge wb_clk_i); core_frame_start = 1'b1;
    @(posedge wb_clk_i); #1; core_frame_start = 1'b0;
  endtask

  task automatic pulse_done();
    @(negedge wb_clk_i); core_frame_done = 1'b1;
    @(posedge wb_clk_i); #1; core_frame_done = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    checks++; if (s_wb_ack_o !== 1'b0) begin errors++; $display("FAIL rst_ack got=%b need=0", s_wb_ack_o); end
    checks++; if (s_wb_dat_o !== 32'h0) begin errors++; $display("FAIL rst_dat got=%h need=0", s_wb_dat_o); end
    checks++; if (core_enable !== 1'b0) begin errors++; $display("FAIL rst_enable got=%b need=0", core_enable); end
    checks++; if (core_awlen !== 8'd15) begin errors++; $display("FAIL rst_awlen got=%0d need=15", core_awlen); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq got=%b need=0", irq); end
    wb_read(8'h00, d);
    checks++; if (d !== 32'h527a0110) begin errors++; $display("FAIL read_id got=%h need=527a0110", d); end
    @(posedge wb_clk_i); #1;
    checks++; if (s_wb_ack_o !== 1'b0) begin errors++; $display("FAIL ack_one_cycle got=%b need=0", s_wb_ack_o); end
    wb_read(8'h01, d);
    checks++; if (d !== 32'h00010000) begin errors++; $display("FAIL read_version got=%h need=00010000", d); end
    wb_read(8'h0f, d);
    checks++; if (d !== 32'd15) begin errors++; $display("FAIL read_awlen got=%h need=0000000f", d); end
    wb_write(8'h02, 32'hffffffff, 4'hf);
    wb_read(8'h02, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL read_unmapped got=%h need=0", d); end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] d;
    wb_write(8'h0a, 32'd2048, 4'b0011);
    wb_read(8'h0a, d);
    checks++; if (d !== 32'h00000800) begin errors++; $display("FAIL lane_lo got=%h need=00000800", d); end
    wb_write(8'h0a, 32'h12345678, 4'b1111);
    wb_read(8'h0a, d);
    checks++; if (d !== 32'h12345678) begin errors++; $display("FAIL lane_all got=%h need=12345678", d); end
    wb_write(8'h0a, 32'haabbccdd, 4'b0100);
    wb_read(8'h0a, d);
    checks++; if (d !== 32'h12bb5678) begin errors++; $display("FAIL lane_b2 got=%h need=12bb5678", d); end
    wb_write(8'h0f, 32'hffffff07, 4'b1111);
    wb_read(8'h0f, d);
    checks++; if (d !== 32'h00000007) begin errors++; $display("FAIL awlen_trunc got=%h need=00000007", d); end
  endtask

  task automatic test_commit();
    logic [31:0] d;
    wb_write(8'h08, 32'h10000000, 4'hf);
    wb_write(8'h09, 32'h00002000, 4'hf);
    wb_write(8'h0a, 32'd640, 4'hf);
    wb_write(8'h0b, 32'd480, 4'hf);
    wb_write(8'h0c, 32'd307200, 4'hf);
    checks++; if (core_width !== 32'd0) begin errors++; $display("FAIL shadow_precommit got=%0d need=0", core_width); end
    wb_write(8'h04, 32'd3, 4'hf);
    checks++; if (core_enable !== 1'b1) begin errors++; $display("FAIL enable_set got=%b need=1", core_enable); end
    wb_read(8'h05, d);
    checks++; if (d !== 32'd6) begin errors++; $display("FAIL status_pending got=%h need=6", d); end
    pulse_start();
    checks++; if (core_width !== 32'd640) begin errors++; $display("FAIL commit_width got=%0d need=640", core_width); end
    checks++; if (core_addr !== 32'h10000000) begin errors++; $display("FAIL commit_addr got=%h need=10000000", core_addr); end
    checks++; if (core_stride !== 32'h2000) begin errors++; $display("FAIL commit_stride got=%h need=2000", core_stride); end
    checks++; if (core_height !== 32'd480) begin errors++; $display("FAIL commit_height got=%0d need=480", core_height); end
    checks++; if (core_size !== 32'd307200) begin errors++; $display("FAIL commit_size got=%0d need=307200", core_size); end
    checks++; if (core_awlen !== 8'd7) begin errors++; $display("FAIL commit_awlen got=%0d need=7", core_awlen); end
    core_busy = 1'b1;
    wb_read(8'h05, d);
    checks++; if (d !== 32'd5) begin errors++; $display("FAIL status_committed got=%h need=5", d); end
    core_busy = 1'b0;
    wb_read(8'h06, d);
    checks++; if (d !== 32'd1) begin errors++; $display("FAIL index_one got=%0d need=1", d); end
    // frame start without an update request leaves the shadows alone
    wb_write(8'h0a, 32'd100, 4'hf);
    pulse_start();
    checks++; if (core_width !== 32'd640) begin errors++; $display("FAIL no_commit_width got=%0d need=640", core_width); end
    wb_read(8'h06, d);
    checks++; if (d !== 32'd1) begin errors++; $display("FAIL no_commit_index got=%0d need=1", d); end
    // write in the commit cycle: shadow takes the old value
    wb_write(8'h04, 32'd3, 4'hf);
    wb_xfer(8'h0a, 1'b1, 32'd320, 4'hf, 1'b1, 1'b0, d);
    checks++; if (core_width !== 32'd100) begin errors++; $display("FAIL race_shadow got=%0d need=100", core_width); end
    wb_read(8'h0a, d);
    checks++; if (d !== 32'd320) begin errors++; $display("FAIL race_reg got=%0d need=320", d); end
    wb_read(8'h06, d);
    checks++; if (d !== 32'd2) begin errors++; $display("FAIL index_two got=%0d need=2", d); end
  endtask

  task automatic test_oneshot();
    logic [31:0] d;
    wb_write(8'h04, 32'd7, 4'hf);
    pulse_done();
    checks++; if (core_enable !== 1'b0) begin errors++; $display("FAIL oneshot_enable got=%b need=0", core_enable); end
    wb_read(8'h04, d);
    checks++; if (d !== 32'd6) begin errors++; $display("FAIL oneshot_ctl got=%h need=6", d); end
    wb_write(8'h04, 32'd7, 4'hf);
    wb_xfer(8'h04, 1'b1, 32'd7, 4'hf, 1'b0, 1'b1, d);
    checks++; if (core_enable !== 1'b1) begin errors++; $display("FAIL write_wins_enable got=%b need=1", core_enable); end
    wb_read(8'h04, d);
    checks++; if (d !== 32'd7) begin errors++; $display("FAIL write_wins_ctl got=%h need=7", d); end
  endtask

  task automatic test_back_to_back();
    int acks;
    logic [31:0] d;
    acks = 0;
    @(negedge wb_clk_i);
    s_wb_adr_i = 8'h00; s_wb_we_i = 1'b0; s_wb_sel_i = 4'hf; s_wb_stb_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge wb_clk_i); #1;
      if (s_wb_ack_o) acks++;
    end
    s_wb_stb_i = 1'b0;
    checks++; if (acks !== 3) begin errors++; $display("FAIL held_stb_acks got=%0d need=3", acks); end
    // reset arrives before the acceptance edge; the access must vanish
    acks = 0;
    @(negedge wb_clk_i);
    s_wb_adr_i = 8'h04; s_wb_stb_i = 1'b1;
    #2 wb_rst_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge wb_clk_i); #1;
      if (s_wb_ack_o) acks++;
    end
    s_wb_stb_i = 1'b0;
    @(negedge wb_clk_i); wb_rst_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge wb_clk_i); #1;
      if (s_wb_ack_o) acks++;
    end
    checks++; if (acks !== 0) begin errors++; $display("FAIL reset_drop_acks got=%0d need=0", acks); end
    checks++; if (core_width !== 32'd0) begin errors++; $display("FAIL reset_shadow got=%0d need=0", core_width); end
    checks++; if (core_awlen !== 8'd15) begin errors++; $display("FAIL reset_awlen got=%0d need=15", core_awlen); end
    wb_read(8'h04, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_ctl got=%h need=0", d); end
    wb_read(8'h06, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_index got=%0d need=0", d); end
    wb_read(8'h0a, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_width_reg got=%0d need=0", d); end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    wb_write(8'h10, 32'd1, 4'hf);
    pulse_done();
`ifdef JELLY_VDMA_WRITE_REGS_IRQ_EN
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set got=%b need=1", irq); end
    wb_read(8'h11, d);
    checks++; if (d !== 32'd1) begin errors++; $display("FAIL irq_status got=%h need=1", d); end
    wb_write(8'h11, 32'd1, 4'hf);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear got=%b need=0", irq); end
    wb_read(8'h11, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL irq_status_clr got=%h need=0", d); end
`else
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_off got=%b need=0", irq); end
    wb_read(8'h10, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL irq_enable_off got=%h need=0", d); end
    wb_read(8'h11, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL irq_status_off got=%h need=0", d); end
`endif
  endtask

  initial begin
    repeat (3) @(negedge wb_clk_i);
    wb_rst_i = 1'b1;
    @(posedge wb_clk_i); #1;
    test_reset();
    test_byte_lanes();
    test_commit();
    test_oneshot();
    test_back_to_back();
    test_irq();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
